wb_stage: RTL

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage_pkg.sv | 30 +++
 rtl/wb_lane_unpack.sv | 18 +
 rtl/wb_stage.sv | 67 ++++++
 3 files changed

// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: bus widths, field offsets, FSM encoding and the unpacked lane record shared by wb_stage
package wb_stage_pkg;
  localparam int ES_TO_WS_BUS_WD = 119;
  localparam int FORWAED_BUS_WD  = 86;
  localparam int BUS_PC        = 0;
  localparam int BUS_RESULT    = 32;
  localparam int BUS_DEST      = 64;
  localparam int BUS_GR_WE     = 69;
  localparam int BUS_CSR_WDATA = 70;
  localparam int BUS_CSR_ADDR  = 102;
  localparam int BUS_CSR_WEN   = 116;
  localparam int BUS_TLBWR     = 117;
  localparam int BUS_TLBRD     = 118;
  typedef enum logic {IDLE = 1'b0, SECOND = 1'b1} state_e;
  typedef struct packed {
    logic        live;
    logic        tlbrd;
    logic        tlbwr;
    logic        csr_wen;
    logic [13:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        rf_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } lane_t;
  function automatic logic side_effect(input lane_t l);
    return l.csr_wen | l.tlbrd | l.tlbwr;
  endfunction
endpackage

// File: rtl/wb_lane_unpack.sv
// wb_lane_unpack: slices one execute lane bus (valid_i, bus_i) into a lane_t record (lane_o) with live and masked regfile write decode
import wb_stage_pkg::*;
module wb_lane_unpack (
  input  logic [1:0]                 valid_i,
  input  logic [ES_TO_WS_BUS_WD-1:0] bus_i,
  output lane_t                      lane_o
);
  assign lane_o.live      = valid_i == 2'b11;
  assign lane_o.tlbrd     = bus_i[BUS_TLBRD];
  assign lane_o.tlbwr     = bus_i[BUS_TLBWR];
  assign lane_o.csr_wen   = bus_i[BUS_CSR_WEN];
  assign lane_o.csr_addr  = bus_i[BUS_CSR_ADDR +: 14];
  assign lane_o.csr_wdata = bus_i[BUS_CSR_WDATA +: 32];
  assign lane_o.dest      = bus_i[BUS_DEST +: 5];
  assign lane_o.rf_we     = bus_i[BUS_GR_WE] & |bus_i[BUS_DEST +: 5];
  assign lane_o.result    = bus_i[BUS_RESULT +: 32];
  assign lane_o.pc        = bus_i[BUS_PC +: 32];
endmodule

// File: rtl/wb_stage.sv
// wb_stage: dual-lane writeback; in es0/es1 valid+bus, out ws_ready, two rf ports, one csr port, tlb pulses, forward buses, retire_cnt, debug pcs
import wb_stage_pkg::*;
module wb_stage (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [1:0]                 es0_to_ws_valid,
  input  logic [ES_TO_WS_BUS_WD-1:0] es0_to_ws_bus,
  input  logic [1:0]                 es1_to_ws_valid,
  input  logic [ES_TO_WS_BUS_WD-1:0] es1_to_ws_bus,
  output logic                       ws_ready,
  output logic                       rf_we0,
  output logic [4:0]                 rf_waddr0,
  output logic [31:0]                rf_wdata0,
  output logic                       rf_we1,
  output logic [4:0]                 rf_waddr1,
  output logic [31:0]                rf_wdata1,
  output logic                       csr_we,
  output logic [13:0]                csr_waddr,
  output logic [31:0]                csr_wdata,
  output logic                       tlbrd_we,
  output logic                       tlbwr_we,
  output logic [FORWAED_BUS_WD-1:0]  forward_data1,
  output logic [FORWAED_BUS_WD-1:0]  forward_data2,
  output logic [63:0]                retire_cnt,
  output logic [31:0]                debug_wb_pc0,
  output logic [31:0]                debug_wb_pc1
);
  lane_t l0, l1;
  state_e state_q, state_d;
  logic conflict, c0, c1;
  logic [63:0] retire_cnt_q;
  wb_lane_unpack u_lane0 (.valid_i(es0_to_ws_valid), .bus_i(es0_to_ws_bus), .lane_o(l0));
  wb_lane_unpack u_lane1 (.valid_i(es1_to_ws_valid), .bus_i(es1_to_ws_bus), .lane_o(l1));
  // Two side-effecting lanes never share a cycle; the held pair is replayed in SECOND for lane 1 only.
  always_comb begin
    conflict = l0.live & l1.live & side_effect(l0) & side_effect(l1);
    c0       = resetn & (state_q == IDLE) & l0.live;
    c1       = resetn & l1.live & ((state_q == SECOND) | ~conflict);
    ws_ready = ~resetn | (state_q == SECOND) | ~conflict;
    state_d  = (state_q == IDLE && conflict) ? SECOND : IDLE;
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      retire_cnt_q <= retire_cnt_q + 64'(c0) + 64'(c1);
    end
  end
  assign rf_we0        = c0 & l0.rf_we & ~(c1 & l1.rf_we & (l0.dest == l1.dest));
  assign rf_waddr0     = l0.dest;
  assign rf_wdata0     = l0.result;
  assign rf_we1        = c1 & l1.rf_we;
  assign rf_waddr1     = l1.dest;
  assign rf_wdata1     = l1.result;
  assign csr_we        = (c0 & l0.csr_wen) | (c1 & l1.csr_wen);
  assign csr_waddr     = (c1 & l1.csr_wen) ? l1.csr_addr : l0.csr_addr;
  assign csr_wdata     = (c1 & l1.csr_wen) ? l1.csr_wdata : l0.csr_wdata;
  assign tlbrd_we      = (c0 & l0.tlbrd) | (c1 & l1.tlbrd);
  assign tlbwr_we      = (c0 & l0.tlbwr) | (c1 & l1.tlbwr);
  assign forward_data1 = {c0, l0.csr_wen, l0.csr_addr, l0.csr_wdata, l0.rf_we, l0.dest, l0.result};
  assign forward_data2 = {c1, l1.csr_wen, l1.csr_addr, l1.csr_wdata, l1.rf_we, l1.dest, l1.result};
  assign retire_cnt    = retire_cnt_q;
  assign debug_wb_pc0  = c0 ? l0.pc : 32'd0;
  assign debug_wb_pc1  = c1 ? l1.pc : 32'd0;
endmodule
